// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
//   SPI mode 0 (CPOL=0, CPHA=0), MSB-first slave. All pins are
//   oversampled by clk through SYNC_STAGES-deep synchronizers; SCK
//   edges are found by comparing the last synchronizer stage with one
//   further registered copy.
//
//   A TX shadow register (written by miso_load) feeds the TX shift
//   register at the start of every word. Words may run back-to-back
//   while CS stays low. A load that lands on the same clk as a
//   shadow-to-shift copy is forwarded straight into the shift register.
//
//   Optional feature: define SPI_SLAVE_MISO_TRISTATE_EN to float MISO
//   (1'bz) while idle or in reset; otherwise MISO is driven 0 when idle.
//
// Parameters
//   DATA_WIDTH   bits per frame (>= 2)
//   SYNC_STAGES  synchronizer depth on SCK/CS/MOSI (>= 2)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   SCK, CS, MOSI  SPI pins from the master (asynchronous, CS active-low)
//   MISO         serial data to the master
//   miso_data    next word to transmit
//   miso_load    one-clk strobe writing miso_data into the TX shadow
//   mosi_data    last complete received word
//   mosi_valid   one-clk pulse when mosi_data updates
//   busy         high while the synchronized CS is low
// ---------------------------------------------------------------------------
module spi_slave #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  SCK,
   input  logic                  CS,
   input  logic                  MOSI,
   output logic                  MISO,
   input  logic [DATA_WIDTH-1:0] miso_data,
   input  logic                  miso_load,
   output logic [DATA_WIDTH-1:0] mosi_data,
   output logic                  mosi_valid,
   output logic                  busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sck_p1;
   logic                   cs_p1;

   logic sck_s, cs_s, mosi_s;
   logic sck_rise, sck_fall, cs_fall, cs_rise;

   logic [0:0]            state;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  word_done;
   logic [DATA_WIDTH-1:0] shadow;
   logic [DATA_WIDTH-1:0] tx;
   logic [DATA_WIDTH-2:0] rx;
   logic [DATA_WIDTH-1:0] rx_next;
   logic [DATA_WIDTH-1:0] tx_src;

   // Synchronizers reset to the idle bus levels so no edge is seen on
   // leaving reset while the pins are idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync  <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sck_p1    <= 1'b0;
         cs_p1     <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         sck_p1    <= sck_sync[SYNC_STAGES-1];
         cs_p1     <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_p1;
   assign sck_fall = ~sck_s & sck_p1;
   assign cs_fall  = ~cs_s & cs_p1;
   assign cs_rise  = cs_s & ~cs_p1;

   // A load coinciding with a copy into the shift register is forwarded.
   assign tx_src  = miso_load ? miso_data : shadow;
   assign rx_next = {rx, mosi_s};

   // Control: FSM, bit counter, shadow and received-word output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         word_done  <= 1'b0;
         mosi_valid <= 1'b0;
         mosi_data  <= '0;
         shadow     <= '0;
      end else begin
         mosi_valid <= 1'b0;
         if (miso_load) shadow <= miso_data;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state     <= SHIFT;
                  bit_cnt   <= '0;
                  word_done <= 1'b0;
               end
            end
            default: begin
               // CS rising wins over a coincident SCK edge; partial bits
               // are simply never copied out.
               if (cs_rise) begin
                  state     <= IDLE;
                  bit_cnt   <= '0;
                  word_done <= 1'b0;
               end else if (sck_rise) begin
                  if (bit_cnt == LAST_BIT) begin
                     mosi_data  <= rx_next;
                     mosi_valid <= 1'b1;
                     bit_cnt    <= '0;
                     word_done  <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end else if (sck_fall) begin
                  word_done <= 1'b0;
               end
            end
         endcase
      end
   end

   // Shift registers: contents are don't-care while idle, so no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         if (cs_fall) tx <= tx_src;
      end else if (!cs_rise) begin
         if (sck_rise) begin
            rx <= rx_next[DATA_WIDTH-2:0];
         end else if (sck_fall) begin
            tx <= word_done ? tx_src : {tx[DATA_WIDTH-2:0], 1'b0};
         end
      end
   end

   assign busy = ~cs_s;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
   assign MISO = (state == SHIFT && !rst) ? tx[DATA_WIDTH-1] : 1'bz;
`else
   assign MISO = (state == SHIFT && !rst) ? tx[DATA_WIDTH-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
//   Bit-banged SPI mode 0 master at clk/10 driving spi_slave. The
//   reference model is a word-level view: every word the slave sends is
//   the shadow value at word start (loads during a word affect the next
//   one, a load on the CS-fall copy is sent at once), and every word the
//   master sends comes back once on mosi_data with one mosi_valid pulse.
// ---------------------------------------------------------------------------
module tb_spi_slave;

   localparam int DW   = 8;
   localparam int SS   = 2;
   localparam int HALF = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          SCK = 1'b0;
   logic          CS = 1'b1;
   logic          MOSI = 1'b0;
   logic          miso_load = 1'b0;
   logic [DW-1:0] miso_data = '0;
   wire           MISO;
   logic [DW-1:0] mosi_data;
   logic          mosi_valid;
   logic          busy;

   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] vq[$];
   logic [DW-1:0] shadow_m = '0;
   logic          miso_idle;

   spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
      .clk        (clk),
      .rst        (rst),
      .SCK        (SCK),
      .CS         (CS),
      .MOSI       (MOSI),
      .MISO       (MISO),
      .miso_data  (miso_data),
      .miso_load  (miso_load),
      .mosi_data  (mosi_data),
      .mosi_valid (mosi_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mosi_valid === 1'b1) vq.push_back(mosi_data);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [DW-1:0] v);
      miso_data = v;
      miso_load = 1'b1;
      @(negedge clk);
      miso_load = 1'b0;
      shadow_m  = v;
   endtask

   task automatic cs_down();
      CS = 1'b0;
      wclk(6);
   endtask

   task automatic cs_up();
      wclk(2);
      CS   = 1'b1;
      MOSI = 1'b0;
      wclk(8);
   endtask

   task automatic spi_bit(input logic b, output logic got);
      MOSI = b;
      wclk(HALF);
      got = MISO;
      SCK = 1'b1;
      wclk(HALF);
      SCK = 1'b0;
   endtask

   task automatic spi_word(input logic [DW-1:0] w, input bit ld, input logic [DW-1:0] lv,
                           output logic [DW-1:0] r);
      logic b;
      for (int i = DW - 1; i >= 0; i--) begin
         if (ld && i == 3) load(lv);
         spi_bit(w[i], b);
         r[i] = b;
      end
   endtask

   task automatic run_frame(input int nw, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                            input logic [DW-1:0] w2, input bit ld, input logic [DW-1:0] lv,
                            input string tag);
      logic [DW-1:0] ws[3];
      logic [DW-1:0] exp_tx;
      logic [DW-1:0] r;
      ws = '{w0, w1, w2};
      vq.delete();
      cs_down();
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      for (int k = 0; k < nw; k++) begin
         exp_tx = shadow_m;
         spi_word(ws[k], ld && k == 0, lv, r);
         check($sformatf("%s_miso%0d", tag, k), {24'b0, r}, {24'b0, exp_tx});
      end
      cs_up();
      check({tag, "_nvalid"}, vq.size(), nw);
      for (int k = 0; k < nw && k < vq.size(); k++)
         check($sformatf("%s_rx%0d", tag, k), {24'b0, vq[k]}, {24'b0, ws[k]});
      check({tag, "_mosi_data"}, {24'b0, mosi_data}, {24'b0, ws[nw-1]});
      check({tag, "_idle_miso"}, {31'b0, MISO}, {31'b0, miso_idle});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] r;
      logic          b;
      int            nw;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
      miso_idle = 1'bz;
`else
      miso_idle = 1'b0;
`endif
      // Reset state
      wclk(3);
      rst = 1'b0;
      wclk(1);
      check("rst_miso", {31'b0, MISO}, {31'b0, miso_idle});
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_valid", {31'b0, mosi_valid}, 32'd0);
      check("rst_mosi_data", {24'b0, mosi_data}, 32'd0);

      // Single word exchange
      load(8'hA5);
      wclk(2);
      run_frame(1, 8'hC9, 8'h00, 8'h00, 1'b0, 8'h00, "single");

      // Back-to-back words with a new load during word 1
      run_frame(2, 8'h11, 8'h22, 8'h00, 1'b1, 8'h3C, "b2b");

      // Aborted word after 5 SCK cycles
      vq.delete();
      cs_down();
      for (int i = 0; i < 5; i++) spi_bit(1'($urandom_range(1)), b);
      cs_up();
      check("abort_nvalid", vq.size(), 32'd0);
      check("abort_mosi_data", {24'b0, mosi_data}, 32'h22);
      run_frame(1, 8'h5A, 8'h00, 8'h00, 1'b0, 8'h00, "after_abort");

      // Load coinciding with the CS-fall copy is sent directly
      vq.delete();
      CS = 1'b0;
      wclk(SS);
      load(8'h81);
      wclk(4);
      check("bypass_first_bit", {31'b0, MISO}, 32'd1);
      spi_word(8'h96, 1'b0, 8'h00, r);
      cs_up();
      check("bypass_rx", {24'b0, r}, 32'h81);
      check("bypass_mosi", {24'b0, mosi_data}, 32'h96);

      // MOSI held high
      run_frame(1, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, "ones");

      // Reset mid-word
      vq.delete();
      cs_down();
      for (int i = 0; i < 3; i++) spi_bit(1'b1, b);
      rst = 1'b1;
      wclk(1);
      check("midrst_miso", {31'b0, MISO}, {31'b0, miso_idle});
      check("midrst_busy", {31'b0, busy}, 32'd0);
      CS  = 1'b1;
      rst = 1'b0;
      wclk(1);
      check("postrst_busy", {31'b0, busy}, 32'd0);
      check("postrst_mosi_data", {24'b0, mosi_data}, 32'd0);
      wclk(12);
      check("postrst_nvalid", vq.size(), 32'd0);
      shadow_m = '0;
      run_frame(1, 8'($urandom), 8'h00, 8'h00, 1'b0, 8'h00, "postrst");

      // Idle MISO level with CS high
      check("idle_miso", {31'b0, MISO}, {31'b0, miso_idle});

      // Randomized frames
      for (int f = 0; f < 8; f++) begin
         if ($urandom_range(1) == 1) begin
            load(8'($urandom));
            wclk(1);
         end
         nw = int'($urandom_range(1, 3));
         run_frame(nw, 8'($urandom), 8'($urandom), 8'($urandom),
                   1'($urandom_range(1)), 8'($urandom), $sformatf("rnd%0d", f));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
